// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot-time framed program loader driving instruction RAM and CPU reset
//
// Purpose:
//   Receives a byte stream framed as {header, N data bytes, checksum}. It writes the data bytes
//   to RAM addresses 0..N-1 and keeps the CPU in reset until a frame arrives with a matching
//   checksum. It then releases the CPU after a short hold-off. A reload pulse puts the CPU
//   back in reset and returns the loader to waiting for a new frame.
//   Build option LOADER_ZFILL_EN: after a good checksum, zero-fill addresses N..2**ADDR_W-1
//   before the hold-off.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   stream byte valid
//   in_data    stream byte
//   in_ready   loader accepts a byte (transfer = in_valid & in_ready)
//   reload     one-cycle request to re-hold the CPU and wait for a new frame
//   ram_addr   RAM write address
//   ram_wdata  RAM write data
//   ram_we     RAM write strobe, one cycle per byte
//   cpu_reset  active-high reset to the CPU
//   load_done  program loaded and CPU running
//   load_err   last header or checksum was bad

module prog_loader #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 8,
   parameter int RELEASE_DLY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_err
);

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CSUM,
      S_ZFILL,
      S_HOLD,
      S_RUN,
      S_ERR
   } state_t;

   state_t             state, state_d;
   logic [ADDR_W-1:0]  idx, idx_d;
   logic [ADDR_W-1:0]  last_idx, last_d;
   logic [DATA_W-1:0]  sum, sum_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               we_d;
   logic [ADDR_W-1:0]  addr_d;
   logic [DATA_W-1:0]  wdata_d;
   logic               err_d;
   logic               xfer;
   logic               hdr_ok;

   assign xfer   = in_valid & in_ready;
   assign hdr_ok = (in_data[DATA_W-1:ADDR_W] == '0);

   always_comb begin
      state_d = state;
      idx_d   = idx;
      last_d  = last_idx;
      sum_d   = sum;
      cnt_d   = '0;
      we_d    = 1'b0;
      addr_d  = ram_addr;
      wdata_d = ram_wdata;
      err_d   = load_err;

      // reload beats any transfer on the same edge; the byte is dropped
      if (reload) begin
         state_d = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_ERR: begin
               if (xfer) begin
                  if (hdr_ok) begin
                     state_d = S_LOAD;
                     idx_d   = '0;
                     sum_d   = '0;
                     // length 0 encodes a full RAM; the subtraction wraps to the top address
                     last_d  = in_data[ADDR_W-1:0] - ADDR_W'(1);
                     err_d   = 1'b0;
                  end else begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (xfer) begin
                  we_d    = 1'b1;
                  addr_d  = idx;
                  wdata_d = in_data;
                  sum_d   = sum + in_data;
                  if (idx == last_idx) begin
                     state_d = S_CSUM;
                  end else begin
                     idx_d = idx + ADDR_W'(1);
                  end
               end
            end
            S_CSUM: begin
               if (xfer) begin
                  if (in_data == sum) begin
`ifdef LOADER_ZFILL_EN
                     if (last_idx == '1) begin
                        state_d = S_HOLD;
                     end else begin
                        state_d = S_ZFILL;
                        idx_d   = last_idx + ADDR_W'(1);
                     end
`else
                     state_d = S_HOLD;
`endif
                  end else begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end
               end
            end
`ifdef LOADER_ZFILL_EN
            S_ZFILL: begin
               we_d    = 1'b1;
               addr_d  = idx;
               wdata_d = '0;
               if (idx == '1) begin
                  state_d = S_HOLD;
               end else begin
                  idx_d = idx + ADDR_W'(1);
               end
            end
`endif
            S_HOLD: begin
               if (cnt == CNT_W'(RELEASE_DLY - 1)) begin
                  state_d = S_RUN;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               state_d = S_RUN;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Status outputs are decoded from the next state so that they change on the same edge as the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         last_idx  <= '0;
         sum       <= '0;
         cnt       <= '0;
         in_ready  <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cpu_reset <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state     <= state_d;
         idx       <= idx_d;
         last_idx  <= last_d;
         sum       <= sum_d;
         cnt       <= cnt_d;
         in_ready  <= (state_d == S_IDLE) || (state_d == S_LOAD) ||
                      (state_d == S_CSUM) || (state_d == S_ERR);
         ram_we    <= we_d;
         ram_addr  <= addr_d;
         ram_wdata <= wdata_d;
         cpu_reset <= (state_d != S_RUN);
         load_done <= (state_d == S_RUN);
         load_err  <= err_d;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;

   localparam int ADDR_W      = 6;
   localparam int DATA_W      = 8;
   localparam int RELEASE_DLY = 4;
   localparam int DEPTH       = 64;

   logic              clk      = 1'b0;
   logic              reset    = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data  = '0;
   logic              reload   = 1'b0;
   logic              in_ready;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_we;
   logic              cpu_reset;
   logic              load_done;
   logic              load_err;

   int vectors     = 0;
   int miscompares = 0;

   logic [13:0] got_q[$];
   logic [13:0] exp_q[$];
   logic [7:0]  fd[DEPTH];
   logic [7:0]  mem_exp[DEPTH];
   logic [7:0]  obs_mem[DEPTH];

   prog_loader #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .RELEASE_DLY (RELEASE_DLY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .reload    (reload),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .cpu_reset (cpu_reset),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ram_we === 1'b1) got_q.push_back({ram_addr, ram_wdata});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      step();
      reload = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int waited = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (in_ready !== 1'b1 && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 100) chk("accept_timeout", 0, 1);
      step();
      in_valid = 1'b0;
      if (gap) step();
   endtask

   function automatic logic [7:0] frame_sum(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s = s + fd[i];
      return 8'(s % 256);
   endfunction

   task automatic absorb(input string tag);
      int diffs = 0;
      chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({tag, "_write"}, got_q[i], exp_q[i]);
      foreach (got_q[i]) obs_mem[got_q[i][13:8]] = got_q[i][7:0];
      for (int a = 0; a < DEPTH; a++) if (obs_mem[a] !== mem_exp[a]) diffs++;
      chk({tag, "_mem"}, diffs, 0);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_frame(input int n, input logic [7:0] cs, input bit gappy);
      logic [7:0] hdr;
      bit ok;
      int k;
      int expk;
      hdr = 8'(n % 64);
      ok  = (cs == frame_sum(n));
      send_byte(hdr, gappy && ($urandom_range(0, 1) == 1));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({6'(i), fd[i]});
         mem_exp[i] = fd[i];
         send_byte(fd[i], gappy && ($urandom_range(0, 1) == 1));
      end
      send_byte(cs, 1'b0);
      if (ok) begin
         expk = RELEASE_DLY;
`ifdef LOADER_ZFILL_EN
         for (int a = n; a < DEPTH; a++) begin
            exp_q.push_back({6'(a), 8'h00});
            mem_exp[a] = 8'h00;
         end
         expk = RELEASE_DLY + (DEPTH - n);
`endif
         k = 0;
         do begin
            @(posedge clk);
            k++;
            @(negedge clk);
         end while (cpu_reset === 1'b1 && k < 300);
         chk("release_cycles", k, expk);
         chk("done_level", load_done, 1);
         chk("err_clear", load_err, 0);
         chk("run_not_ready", in_ready, 0);
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         in_data  = 8'h77;
         step();
         step();
         in_valid = 1'b0;
         chk("still_running", cpu_reset, 0);
      end else begin
         step();
         step();
         chk("csum_err", load_err, 1);
         chk("csum_cpu_held", cpu_reset, 1);
         chk("csum_not_done", load_done, 0);
         chk("err_ready", in_ready, 1);
      end
      absorb(ok ? "good" : "badcs");
   endtask

   initial begin
      int n;
      logic [7:0] cs;

      for (int a = 0; a < DEPTH; a++) begin
         mem_exp[a] = 8'h00;
         obs_mem[a] = 8'h00;
      end

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_load_done", load_done, 0);
      chk("rst_load_err", load_err, 0);
      reset = 1'b1;
      #1;
      chk("ready_before_edge", in_ready, 0);
      step();
      chk("ready_after_release", in_ready, 1);

      // frame 03 01 02 03 06
      fd[0] = 8'h01; fd[1] = 8'h02; fd[2] = 8'h03;
      do_frame(3, 8'h06, 1'b0);

      // reload while running
      reload = 1'b1;
      @(negedge clk);
      chk("run_before_reload", cpu_reset, 0);
      step();
      reload = 1'b0;
      @(negedge clk);
      chk("reload_cpu_reset", cpu_reset, 1);
      chk("reload_done_low", load_done, 0);
      chk("reload_ready", in_ready, 1);
      step();

      // bad checksum, then recovery from ERR
      do_frame(3, 8'h07, 1'b0);
      fd[0] = 8'hAA;
      do_frame(1, 8'hAA, 1'b0);

      // bad headers, then a full 64-byte frame
      pulse_reload();
      send_byte(8'h40, 1'b0);
      chk("badhdr_err", load_err, 1);
      send_byte(8'h80, 1'b0);
      chk("badhdr_err2", load_err, 1);
      chk("badhdr_ready", in_ready, 1);
      absorb("badhdr");
      for (int i = 0; i < DEPTH; i++) fd[i] = 8'h01;
      do_frame(64, 8'h40, 1'b0);

      // in_valid toggling during load
      pulse_reload();
      for (int i = 0; i < 10; i++) fd[i] = 8'($urandom);
      do_frame(10, frame_sum(10), 1'b1);

      // reload mid-load, with a byte offered on the same edge
      pulse_reload();
      send_byte(8'h08, 1'b0);
      for (int i = 0; i < 5; i++) begin
         fd[i] = 8'($urandom);
         exp_q.push_back({6'(i), fd[i]});
         mem_exp[i] = fd[i];
         send_byte(fd[i], 1'b0);
      end
      in_valid = 1'b1;
      in_data  = 8'h5A;
      reload   = 1'b1;
      step();
      reload   = 1'b0;
      in_valid = 1'b0;
      repeat (3) step();
      chk("abort_cpu_held", cpu_reset, 1);
      chk("abort_ready", in_ready, 1);
      chk("abort_not_done", load_done, 0);
      absorb("abort");
      for (int i = 0; i < 3; i++) fd[i] = 8'($urandom);
      do_frame(3, frame_sum(3), 1'b0);

      // asynchronous reset mid-load
      pulse_reload();
      send_byte(8'h10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         fd[i] = 8'($urandom);
         exp_q.push_back({6'(i), fd[i]});
         mem_exp[i] = fd[i];
         send_byte(fd[i], 1'b0);
      end
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_in_ready", in_ready, 0);
      chk("arst_ram_we", ram_we, 0);
      chk("arst_ram_addr", ram_addr, 0);
      chk("arst_ram_wdata", ram_wdata, 0);
      chk("arst_cpu_reset", cpu_reset, 1);
      chk("arst_load_done", load_done, 0);
      chk("arst_load_err", load_err, 0);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("arst_ready_held", in_ready, 0);
      step();
      chk("arst_ready_back", in_ready, 1);
      absorb("arst");

      // randomized frames
      for (int f = 0; f < 10; f++) begin
         if (load_done === 1'b1) pulse_reload();
         if ($urandom_range(0, 4) == 0) begin
            send_byte(8'($urandom_range(64, 255)), 1'b0);
            chk("rand_badhdr", load_err, 1);
         end
         n = $urandom_range(1, 64);
         for (int i = 0; i < n; i++) fd[i] = 8'($urandom);
         cs = frame_sum(n);
         if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
         do_frame(n, cs, $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
